// File: rtl/kbd_pkg.sv
// Shared constants and types for the PS/2 Set-2 scancode decoder.
// Optional macro KBD_ASCII_EN adds the ASCII-carrying FIFO entry type.
package kbd_pkg;

  // Prefix bytes
  localparam logic [7:0] SC_EXT       = 8'hE0;
  localparam logic [7:0] SC_BRK       = 8'hF0;
  localparam logic [7:0] SC_PAUSE     = 8'hE1;

  // Modifier and special key base codes
  localparam logic [7:0] SC_LSHIFT    = 8'h12;
  localparam logic [7:0] SC_RSHIFT    = 8'h59;
  localparam logic [7:0] SC_CTRL      = 8'h14;
  localparam logic [7:0] SC_ALT       = 8'h11;
  localparam logic [7:0] SC_CAPS      = 8'h58;
  localparam logic [7:0] SC_PAUSE_KEY = 8'h77;

  // Keyboard status bytes that never form a key event
  localparam logic [7:0] SC_BAT       = 8'hAA;
  localparam logic [7:0] SC_ACK       = 8'hFA;
  localparam logic [7:0] SC_RESEND    = 8'hFE;
  localparam logic [7:0] SC_ERR_LO    = 8'h00;
  localparam logic [7:0] SC_ERR_HI    = 8'hFF;

  // Bit positions inside the mods vector
  localparam int MOD_SHIFT_L = 0;
  localparam int MOD_SHIFT_R = 1;
  localparam int MOD_CTRL    = 2;
  localparam int MOD_ALT     = 3;
  localparam int MOD_CAPS    = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_PAUSE
  } kbd_state_t;

  typedef struct packed {
    logic       pause;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } kbd_event_t;

`ifdef KBD_ASCII_EN
  typedef struct packed {
    logic [7:0] ascii;
    kbd_event_t ev;
  } kbd_ascii_event_t;
`endif

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ERR_LO) || (b == SC_ERR_HI);
  endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Small synchronous event FIFO with sticky overflow; head is zero when empty.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = kbd_event_t
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   empty,
  output logic   overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  entry_t      mem [DEPTH];
  logic        full;
  logic        do_pop;
  logic        do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer and sticky overflow update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Storage write
  // NOTE: the array has no reset; entries are only visible once written, and head is masked when empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 byte stream to key-event decoder with modifier tracking and event FIFO.
// Optional macro KBD_ASCII_EN adds the ev_ascii output and its lookup.
module ps2_scancode_decoder
  import kbd_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PAUSE_LEN = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_pause,
  output logic [4:0] mods,
  output logic       overflow
`ifdef KBD_ASCII_EN
  ,
  output logic [7:0] ev_ascii
`endif
);

  localparam int CW = $clog2(PAUSE_LEN + 1);

  kbd_state_t  state_q, state_d;
  logic [CW-1:0] skip_q, skip_d;
  logic        push_en;
  kbd_event_t  push_ev;
  logic [4:0]  mods_q;
  logic        caps_held_q;
  logic        fifo_empty;
  kbd_event_t  head_ev;

  // State register and Pause skip counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Next-state selection on each received byte
  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_data == SC_EXT)        state_d = ST_EXT;
          else if (byte_data == SC_BRK)   state_d = ST_BRK;
          else if (byte_data == SC_PAUSE) begin
            state_d = ST_PAUSE;
            skip_d  = CW'(PAUSE_LEN);
          end
        end
        ST_EXT: begin
          if (byte_data == SC_BRK)        state_d = ST_EXT_BRK;
          else if (byte_data != SC_EXT)   state_d = ST_IDLE;
        end
        ST_BRK, ST_EXT_BRK: state_d = ST_IDLE;
        ST_PAUSE: begin
          skip_d = skip_q - 1'b1;
          if (skip_q == CW'(1)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Push decision and event contents for the current byte
  always_comb begin
    push_en      = 1'b0;
    push_ev      = '0;
    push_ev.code = byte_data;
    if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          push_en = (byte_data != SC_EXT) && (byte_data != SC_BRK) &&
                    (byte_data != SC_PAUSE) && !is_ignored(byte_data);
        end
        ST_EXT: begin
          push_en     = (byte_data != SC_EXT) && (byte_data != SC_BRK);
          push_ev.ext = 1'b1;
        end
        ST_BRK: begin
          push_en     = (byte_data != SC_EXT) && (byte_data != SC_BRK);
          push_ev.brk = 1'b1;
        end
        ST_EXT_BRK: begin
          push_en     = (byte_data != SC_EXT) && (byte_data != SC_BRK);
          push_ev.ext = 1'b1;
          push_ev.brk = 1'b1;
        end
        ST_PAUSE: begin
          if (skip_q == CW'(1)) begin
            push_en       = 1'b1;
            push_ev.code  = SC_PAUSE_KEY;
            push_ev.pause = 1'b1;
          end
        end
        default: push_en = 1'b0;
      endcase
    end
  end

  // Modifier state follows every decoded event, whether or not the FIFO keeps it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mods_q      <= '0;
      caps_held_q <= 1'b0;
    end else if (push_en && !push_ev.pause) begin
      if (push_ev.code == SC_LSHIFT && !push_ev.ext) mods_q[MOD_SHIFT_L] <= !push_ev.brk;
      if (push_ev.code == SC_RSHIFT) mods_q[MOD_SHIFT_R] <= !push_ev.brk;
      if (push_ev.code == SC_CTRL)   mods_q[MOD_CTRL]    <= !push_ev.brk;
      if (push_ev.code == SC_ALT)    mods_q[MOD_ALT]     <= !push_ev.brk;
      if (push_ev.code == SC_CAPS) begin
        if (!push_ev.brk) begin
          if (!caps_held_q) mods_q[MOD_CAPS] <= !mods_q[MOD_CAPS];
          caps_held_q <= 1'b1;
        end else begin
          caps_held_q <= 1'b0;
        end
      end
    end
  end

`ifdef KBD_ASCII_EN
  kbd_ascii_event_t push_entry, head_entry;
  logic [7:0]       ascii_d;
  logic             is_letter;

  // ASCII lookup of the event being pushed; case uses modifier state before this byte
  always_comb begin
    ascii_d   = 8'h00;
    is_letter = 1'b0;
    if (!push_ev.ext && !push_ev.pause) begin
      is_letter = 1'b1;
      case (push_ev.code)
        8'h1C: ascii_d = 8'h61;  8'h32: ascii_d = 8'h62;  8'h21: ascii_d = 8'h63;
        8'h23: ascii_d = 8'h64;  8'h24: ascii_d = 8'h65;  8'h2B: ascii_d = 8'h66;
        8'h34: ascii_d = 8'h67;  8'h33: ascii_d = 8'h68;  8'h43: ascii_d = 8'h69;
        8'h3B: ascii_d = 8'h6A;  8'h42: ascii_d = 8'h6B;  8'h4B: ascii_d = 8'h6C;
        8'h3A: ascii_d = 8'h6D;  8'h31: ascii_d = 8'h6E;  8'h44: ascii_d = 8'h6F;
        8'h4D: ascii_d = 8'h70;  8'h15: ascii_d = 8'h71;  8'h2D: ascii_d = 8'h72;
        8'h1B: ascii_d = 8'h73;  8'h2C: ascii_d = 8'h74;  8'h3C: ascii_d = 8'h75;
        8'h2A: ascii_d = 8'h76;  8'h1D: ascii_d = 8'h77;  8'h22: ascii_d = 8'h78;
        8'h35: ascii_d = 8'h79;  8'h1A: ascii_d = 8'h7A;
        default: begin
          is_letter = 1'b0;
          case (push_ev.code)
            8'h45: ascii_d = 8'h30;  8'h16: ascii_d = 8'h31;  8'h1E: ascii_d = 8'h32;
            8'h26: ascii_d = 8'h33;  8'h25: ascii_d = 8'h34;  8'h2E: ascii_d = 8'h35;
            8'h36: ascii_d = 8'h36;  8'h3D: ascii_d = 8'h37;  8'h3E: ascii_d = 8'h38;
            8'h46: ascii_d = 8'h39;  8'h29: ascii_d = 8'h20;  8'h5A: ascii_d = 8'h0D;
            8'h66: ascii_d = 8'h08;
            default: ascii_d = 8'h00;
          endcase
        end
      endcase
      if (is_letter && ((mods_q[MOD_SHIFT_L] | mods_q[MOD_SHIFT_R]) ^ mods_q[MOD_CAPS]))
        ascii_d = ascii_d - 8'h20;
    end
  end

  assign push_entry = '{ascii: ascii_d, ev: push_ev};
  assign head_ev    = head_entry.ev;
  assign ev_ascii   = head_entry.ascii;

  kbd_event_fifo #(.DEPTH(DEPTH), .entry_t(kbd_ascii_event_t)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_en),
    .push_data (push_entry),
    .pop       (ev_ready),
    .head      (head_entry),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );
`else
  kbd_event_fifo #(.DEPTH(DEPTH), .entry_t(kbd_event_t)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_en),
    .push_data (push_ev),
    .pop       (ev_ready),
    .head      (head_ev),
    .empty     (fifo_empty),
    .overflow  (overflow)
  );
`endif

  assign ev_valid = !fifo_empty;
  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign ev_break = head_ev.brk;
  assign ev_pause = head_ev.pause;
  assign mods     = mods_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Randomised scoreboard bench for ps2_scancode_decoder.
// With KBD_ASCII_EN defined it also checks one shifted-letter ASCII value.
module tb_ps2_scancode_decoder;

  localparam int DEPTH     = 4;
  localparam int PAUSE_LEN = 7;

  typedef struct packed {
    logic       pause;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } exp_ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       ev_valid;
  logic       ev_ready = 1'b0;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_pause;
  logic [4:0] mods;
  logic       overflow;
`ifdef KBD_ASCII_EN
  logic [7:0] ev_ascii;
  bit         asc_chk = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  exp_ev_t    exp_q[$];
  logic [7:0] pend[$];
  logic       m_shl, m_shr, m_ctrl, m_alt, m_caps, m_caps_held;
  logic       m_ovf;

  ps2_scancode_decoder #(.DEPTH(DEPTH), .PAUSE_LEN(PAUSE_LEN)) dut (
    .clock      (clock),
    .reset      (reset),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .ev_pause   (ev_pause),
    .mods       (mods),
    .overflow   (overflow)
`ifdef KBD_ASCII_EN
    ,
    .ev_ascii   (ev_ascii)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pend.delete();
    {m_shl, m_shr, m_ctrl, m_alt, m_caps, m_caps_held, m_ovf} = '0;
  endtask

  // Sequence-level decode: pend holds the prefix bytes seen so far
  task automatic model_byte(input logic [7:0] b, output bit emit, output exp_ev_t e);
    bit is_pfx, is_ign, mk;
    emit   = 0;
    e      = '0;
    is_pfx = (b == 8'hE0) || (b == 8'hF0);
    is_ign = (b == 8'hAA) || (b == 8'hFA) || (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    if (pend.size() == 0) begin
      if (is_pfx || b == 8'hE1) pend.push_back(b);
      else if (!is_ign) begin emit = 1; e = '{1'b0, 1'b0, 1'b0, b}; end
    end else if (pend[0] == 8'hE1) begin
      pend.push_back(b);
      if (pend.size() == PAUSE_LEN + 1) begin
        emit = 1; e = '{1'b1, 1'b0, 1'b0, 8'h77}; pend.delete();
      end
    end else if (pend[pend.size()-1] == 8'hF0) begin
      if (!is_pfx) begin emit = 1; e = '{1'b0, 1'b1, pend[0] == 8'hE0, b}; end
      pend.delete();
    end else begin
      if (b == 8'hF0) pend.push_back(b);
      else if (b != 8'hE0) begin emit = 1; e = '{1'b0, 1'b0, 1'b1, b}; pend.delete(); end
    end
    if (emit && !e.pause) begin
      mk = !e.brk;
      if (e.code == 8'h12 && !e.ext) m_shl = mk;
      if (e.code == 8'h59) m_shr  = mk;
      if (e.code == 8'h14) m_ctrl = mk;
      if (e.code == 8'h11) m_alt  = mk;
      if (e.code == 8'h58) begin
        if (mk) begin
          if (!m_caps_held) m_caps = !m_caps;
          m_caps_held = 1;
        end else m_caps_held = 0;
      end
    end
  endtask

  // One byte strobe; entered and left at posedge+1
  task automatic send(input logic [7:0] b, input bit rnd_ready);
    bit      emit;
    exp_ev_t e;
    if (rnd_ready) ev_ready = 1'($urandom_range(0, 1));
    byte_valid = 1'b1;
    byte_data  = b;
    model_byte(b, emit, e);
    @(negedge clock); #1;
    if (emit) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(e);
      else m_ovf = 1;
    end
    @(posedge clock); #1;
    byte_valid = 1'b0;
    check("mods", mods, {m_caps, m_alt, m_ctrl, m_shr, m_shl});
    check("overflow", overflow, m_ovf);
  endtask

  task automatic idle(input int n, input bit rnd_ready);
    for (int i = 0; i < n; i++) begin
      if (rnd_ready) ev_ready = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    ev_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    check("drain_complete", exp_q.size(), 0);
    check("ev_valid_after_drain", ev_valid, 1'b0);
  endtask

  // Monitor: compare the head against the scoreboard on every handshake
  always @(negedge clock) begin
    if (!reset) begin
      check("ev_valid_occupancy", ev_valid, exp_q.size() != 0);
      if (ev_valid && ev_ready && exp_q.size() != 0) begin
        exp_ev_t e;
        e = exp_q.pop_front();
        check("event", {ev_pause, ev_break, ev_ext, ev_code}, e);
`ifdef KBD_ASCII_EN
        if (asc_chk && ev_code == 8'h1C && !ev_ext && !ev_break) check("ascii_upper_a", ev_ascii, 8'h41);
`endif
      end
    end
  end

  logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
  logic [7:0] mod_pool  [5] = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h58};
  logic [7:0] ign_pool  [5] = '{8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF};

  function automatic logic [7:0] rand_byte();
    int r;
    r = $urandom_range(0, 99);
    if (r < 8)  return 8'hE0;
    if (r < 16) return 8'hF0;
    if (r < 18) return 8'hE1;
    if (r < 22) return ign_pool[$urandom_range(0, 4)];
    if (r < 40) return mod_pool[$urandom_range(0, 4)];
    return 8'($urandom_range(1, 8'hDF));
  endfunction

  initial begin
    model_reset();
    idle(3, 0);
    check("rst_ev_valid", ev_valid, 1'b0);
    check("rst_event", {ev_pause, ev_break, ev_ext, ev_code}, 11'h000);
    check("rst_mods", mods, 5'h00);
    check("rst_overflow", overflow, 1'b0);
    reset = 1'b0;
    idle(2, 0);

    // Make with latency check, then break
    ev_ready = 1'b0;
    send(8'h1C, 0);
    check("latency_ev_valid", ev_valid, 1'b1);
    drain();
    send(8'hF0, 0); send(8'h1C, 0);
    drain();

    // Extended make and extended break
    send(8'hE0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    drain();

    // Full Pause sequence then a normal key
    for (int i = 0; i < 8; i++) send(pause_seq[i], 0);
    send(8'h1C, 0);
    drain();

    // Left shift with typematic repeats, then caps lock toggles
    send(8'h12, 0);
    check("shift_l_set", mods[0], 1'b1);
    send(8'h12, 0); send(8'h12, 0); send(8'hF0, 0); send(8'h12, 0);
    check("shift_l_clear", mods[0], 1'b0);
    send(8'h58, 0);
    check("caps_first_toggle", mods[4], 1'b1);
    send(8'h58, 0); send(8'hF0, 0); send(8'h58, 0); send(8'h58, 0);
    check("caps_second_toggle", mods[4], 1'b0);
    drain();

    // Overflow: DEPTH+1 makes with no consumer
    ev_ready = 1'b0;
    send(8'h1C, 0); send(8'h32, 0); send(8'h21, 0); send(8'h23, 0); send(8'h24, 0);
    check("overflow_set", overflow, 1'b1);
    // Push and pop in the same cycle while full: nothing dropped
    ev_ready = 1'b1;
    send(8'h2B, 0);
    ev_ready = 1'b0;
    check("full_push_pop_kept", exp_q.size(), DEPTH);
    drain();

    // Reset between E0 and 75 discards the prefix
    send(8'hE0, 0);
    reset = 1'b1;
    model_reset();
    idle(2, 0);
    check("ev_valid_in_reset", ev_valid, 1'b0);
    check("overflow_cleared", overflow, 1'b0);
    reset = 1'b0;
    idle(1, 0);
    send(8'h75, 0);
    drain();

`ifdef KBD_ASCII_EN
    asc_chk = 1;
    send(8'h12, 0); send(8'h1C, 0);
    drain();
    asc_chk = 0;
    send(8'hF0, 0); send(8'h12, 0);
    drain();
`endif

    // Randomised stream with random back-pressure
    for (int i = 0; i < 600; i++) begin
      send(rand_byte(), 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
